// File: rtl/sram_bridge_pkg.sv
// Shared types and constants for the 32-bit core to 16-bit async SRAM bridge.
//   state_t  : bridge sequencing states
//   WAIT_W   : width of the per-half access wait counter
//   SRAM_OFF : deasserted level of every active-low SRAM strobe
//   HALF_HI / HALF_LO : value of SRAM address bit 0 for each 16-bit half
package sram_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HI_SETUP,
      HI_ACC,
      LO_SETUP,
      LO_ACC,
      DONE
   } state_t;

   localparam int   WAIT_W   = 8;
   localparam logic SRAM_OFF = 1'b1;
   localparam logic HALF_HI  = 1'b0;
   localparam logic HALF_LO  = 1'b1;

endpackage

// File: rtl/sram_bridge.sv
// Bridge between the core's 32-bit load/store/fetch port and a 16-bit
// asynchronous SRAM. Each core access becomes up to two half-accesses
// (HI half at even word address, LO half at odd), data is big-endian.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for cpu_req; request fields latched on acceptance
// HI_SETUP  | address/masks valid for upper half, strobes off (1 cycle)
// HI_ACC    | upper-half strobe active for WAIT_CYCLES cycles
// LO_SETUP  | address/masks valid for lower half, strobes off (1 cycle)
// LO_ACC    | lower-half strobe active for WAIT_CYCLES cycles
// DONE      | cpu_ready pulse, bus released (1 cycle), back to IDLE
//
// Ports:
//   clock, reset       : system clock (rising), async active-low reset
//   cpu_req/we/addr/wdata/be : core request, sampled only in IDLE
//   cpu_rdata, cpu_ready : read data and one-cycle completion pulse
//   addr, data         : SRAM word address and bidirectional data bus
//   wre, oute, hb_mask, lb_mask, chip_en : active-low SRAM strobes
module sram_bridge
   import sram_bridge_pkg::*;
#(
   parameter int WAIT_CYCLES = 1,
   parameter int ADDR_W      = 18,
   parameter int DATA_W      = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   input  logic [3:0]        cpu_be,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_ready,
   output logic [ADDR_W-1:0] addr,
   inout  wire  [DATA_W-1:0] data,
   output logic              wre,
   output logic              oute,
   output logic              hb_mask,
   output logic              lb_mask,
   output logic              chip_en
);

   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES - 1);

   state_t              state;
   state_t              state_nxt;
   logic                we_q;
   logic [ADDR_W-2:0]   line_q;
   logic [ADDR_W-2:0]   line_d;
   logic [31:0]         wdata_q;
   logic [3:0]          be_q;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                wait_done;
   logic                accept;
   logic                half;
   logic [1:0]          sel_be;
   logic                drive;
   logic                unused_addr_bits;

   assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+1], cpu_addr[1:0]};

   assign accept    = (state == IDLE) && cpu_req;
   assign wait_done = (wait_cnt == '0);
   assign half      = (state == LO_SETUP || state == LO_ACC) ? HALF_LO : HALF_HI;
   assign sel_be    = (half == HALF_LO) ? be_q[1:0] : be_q[3:2];
   // In IDLE the address comes straight from the core so a skipped HI half
   // can still load the LO address on the accepting edge.
   assign line_d    = (state == IDLE) ? cpu_addr[ADDR_W:2] : line_q;

   assign data = drive ? ((half == HALF_LO) ? wdata_q[15:0] : wdata_q[31:16]) : 'z;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      chip_en   = SRAM_OFF;
      wre       = SRAM_OFF;
      oute      = SRAM_OFF;
      hb_mask   = SRAM_OFF;
      lb_mask   = SRAM_OFF;
      drive     = 1'b0;
      cpu_ready = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_req) begin
               // Writes skip any half with no enabled bytes; reads never skip.
               if (!cpu_we || (|cpu_be[3:2])) state_nxt = HI_SETUP;
               else if (|cpu_be[1:0])         state_nxt = LO_SETUP;
               else                           state_nxt = DONE;
            end
         end
         HI_SETUP, LO_SETUP: begin
            state_nxt = (state == HI_SETUP) ? HI_ACC : LO_ACC;
            chip_en   = 1'b0;
            hb_mask   = ~sel_be[1];
            lb_mask   = ~sel_be[0];
            drive     = we_q;
         end
         HI_ACC, LO_ACC: begin
            chip_en = 1'b0;
            drive   = we_q;
            if (we_q) begin
               wre     = 1'b0;
               hb_mask = ~sel_be[1];
               lb_mask = ~sel_be[0];
            end else begin
               oute    = 1'b0;
               hb_mask = 1'b0;
               lb_mask = 1'b0;
            end
            if (wait_done) begin
               if (state == LO_ACC)                 state_nxt = DONE;
               else if (!we_q || (|be_q[1:0]))      state_nxt = LO_SETUP;
               else                                 state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
            cpu_ready = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         we_q      <= 1'b0;
         line_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         wait_cnt  <= '0;
         addr      <= '0;
         cpu_rdata <= '0;
      end else begin
         if (accept) begin
            we_q    <= cpu_we;
            line_q  <= cpu_addr[ADDR_W:2];
            wdata_q <= cpu_wdata;
            be_q    <= cpu_be;
         end

         if (state == HI_SETUP || state == LO_SETUP) begin
            wait_cnt <= WAIT_LOAD;
         end else if ((state == HI_ACC || state == LO_ACC) && !wait_done) begin
            wait_cnt <= wait_cnt - 1'b1;
         end

         if (state_nxt == HI_SETUP) begin
            addr <= {line_d, HALF_HI};
         end else if (state_nxt == LO_SETUP) begin
            addr <= {line_d, HALF_LO};
         end

         if (!we_q && wait_done) begin
            if (state == HI_ACC) cpu_rdata[31:16] <= data;
            if (state == LO_ACC) cpu_rdata[15:0]  <= data;
         end
      end
   end

endmodule

// File: tb/tb_sram_bridge.sv
// Bench for sram_bridge: two instances (WAIT_CYCLES 1 and 3), each with a
// behavioural SRAM on its bus and a probe that drives a known pattern
// whenever chip_en is high, so a released bus reads back that pattern.
module tb_sram_bridge;

   localparam int          W0    = 1;
   localparam int          W1    = 3;
   localparam logic [15:0] PROBE = 16'hA5C3;

   typedef struct {
      logic        we;
      logic [31:0] rdata;
      int          rdy_cyc;
      string       tag;
   } exp_t;

   typedef struct packed {
      logic [17:0] a;
      logic [15:0] d;
      logic        ce;
      logic        oe;
      logic        we;
      logic        hb;
      logic        lb;
      logic        rdy;
   } tr_t;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int n_oe1  = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic        req0, we0, req1, we1;
   logic [31:0] ad0, wd0, ad1, wd1;
   logic [3:0]  be0, be1;
   logic [31:0] rd0, rd1;
   logic        rdy0, rdy1;
   logic [17:0] sa0, sa1;
   wire  [15:0] sd0, sd1;
   logic        wre0, oe0, hb0, lb0, ce0;
   logic        wre1, oe1, hb1, lb1, ce1;

   logic [15:0] mem0 [0:1023];
   logic [15:0] mem1 [0:1023];
   logic [15:0] mq0, mq1;

   exp_t q0[$];
   exp_t q1[$];
   tr_t  tr[$];

   sram_bridge #(.WAIT_CYCLES(W0)) dut0 (
      .clock(clock), .reset(reset),
      .cpu_req(req0), .cpu_we(we0), .cpu_addr(ad0), .cpu_wdata(wd0), .cpu_be(be0),
      .cpu_rdata(rd0), .cpu_ready(rdy0),
      .addr(sa0), .data(sd0), .wre(wre0), .oute(oe0),
      .hb_mask(hb0), .lb_mask(lb0), .chip_en(ce0)
   );

   sram_bridge #(.WAIT_CYCLES(W1)) dut1 (
      .clock(clock), .reset(reset),
      .cpu_req(req1), .cpu_we(we1), .cpu_addr(ad1), .cpu_wdata(wd1), .cpu_be(be1),
      .cpu_rdata(rd1), .cpu_ready(rdy1),
      .addr(sa1), .data(sd1), .wre(wre1), .oute(oe1),
      .hb_mask(hb1), .lb_mask(lb1), .chip_en(ce1)
   );

   assign mq0 = mem0[sa0[9:0]];
   assign mq1 = mem1[sa1[9:0]];
   assign sd0 = (!ce0 && !oe0 && wre0) ? mq0 : 16'hzzzz;
   assign sd0 = ce0 ? PROBE : 16'hzzzz;
   assign sd1 = (!ce1 && !oe1 && wre1) ? mq1 : 16'hzzzz;
   assign sd1 = ce1 ? PROBE : 16'hzzzz;

   always @(negedge clock) begin
      if (!ce0 && !wre0) begin
         if (!hb0) mem0[sa0[9:0]][15:8] <= sd0[15:8];
         if (!lb0) mem0[sa0[9:0]][7:0]  <= sd0[7:0];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int lat(input logic we, input logic [3:0] be, input int w);
      int halves;
      halves = we ? (int'(|be[3:2]) + int'(|be[1:0])) : 2;
      return halves * (1 + w) + 1;
   endfunction

   // Scoreboard and bus-protocol monitor, sampled on the falling edge.
   always @(negedge clock) begin
      exp_t e;
      if (rdy0) begin
         if (q0.size() == 0) begin
            check("sb0_unexpected_ready", q0.size(), 1);
         end else begin
            e = q0.pop_front();
            check({e.tag, "_ready_cycle"}, cyc, e.rdy_cyc);
            if (!e.we) check({e.tag, "_rdata"}, rd0, e.rdata);
            check({e.tag, "_done_bus_released"}, sd0, PROBE);
            check({e.tag, "_done_strobes"}, {ce0, wre0, oe0, hb0, lb0}, 5'h1f);
         end
      end
      if (rdy1) begin
         if (q1.size() == 0) begin
            check("sb1_unexpected_ready", q1.size(), 1);
         end else begin
            e = q1.pop_front();
            check({e.tag, "_ready_cycle"}, cyc, e.rdy_cyc);
            if (!e.we) check({e.tag, "_rdata"}, rd1, e.rdata);
            check({e.tag, "_done_bus_released"}, sd1, PROBE);
         end
      end
      if (reset && !oe0) check("p0_oute_with_wre", wre0, 1'b1);
      if (reset && !oe1) begin
         n_oe1 <= n_oe1 + 1;
         check("p1_oute_with_wre", wre1, 1'b1);
         check("p1_read_bus_clean", sd1, mq1);
      end
   end

   // Issue one transaction on dut0 (must be called in an IDLE cycle) and
   // record the bus at every falling edge up to and including DONE.
   task automatic xfer0(input string tag, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp_rd);
      exp_t e;
      bit   seen;
      req0 = 1'b1; we0 = we; ad0 = a; wd0 = wd; be0 = be;
      e.we = we; e.rdata = exp_rd; e.rdy_cyc = cyc + lat(we, be, W0); e.tag = tag;
      q0.push_back(e);
      tr.delete();
      @(negedge clock);
      req0 = 1'b0; we0 = ~we; ad0 = $urandom; wd0 = $urandom; be0 = 4'($urandom);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tr.push_back('{sa0, sd0, ce0, oe0, wre0, hb0, lb0, rdy0});
         if (rdy0) begin
            seen = 1'b1;
            break;
         end
         @(negedge clock);
      end
      if (!seen) check({tag, "_timeout"}, rdy0, 1'b1);
      @(negedge clock);
   endtask

   logic [17:0] ea [4] = '{18'd0, 18'd0, 18'd1, 18'd1};
   logic        eo [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      exp_t e;
      int   c;
      bit   seen;
      reset = 1'b0;
      req0 = 0; we0 = 0; ad0 = 0; wd0 = 0; be0 = 0;
      req1 = 0; we1 = 0; ad1 = 0; wd1 = 0; be1 = 0;
      for (int i = 0; i < 1024; i++) begin
         mem0[i] = 16'h1111;
         mem1[i] = 16'h2222;
      end
      mem0[0] = 16'h3c01; mem0[1] = 16'h1000;
      mem1[0] = 16'h3c01; mem1[1] = 16'h1000;
      mem1[2] = 16'h1234; mem1[3] = 16'h5678;
      #2;
      check("rst_strobes", {ce0, wre0, oe0, hb0, lb0}, 5'h1f);
      check("rst_ready", rdy0, 1'b0);
      check("rst_rdata", rd0, 32'h0);
      check("rst_addr", sa0, 18'h0);
      check("rst_bus_released", sd0, PROBE);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      // Read of word 0: HI then LO, oute only during ACC.
      xfer0("rd0", 1'b0, 32'h0, 32'h0, 4'h0, 32'h3c011000);
      check("rd0_trace_len", tr.size(), 5);
      if (tr.size() == 5) begin
         for (int i = 0; i < 4; i++) begin
            check($sformatf("rd0_addr_c%0d", i), tr[i].a, ea[i]);
            check($sformatf("rd0_oute_c%0d", i), tr[i].oe, eo[i]);
            check($sformatf("rd0_ce_c%0d", i), tr[i].ce, 1'b0);
         end
      end
      check("idle_addr_hold", sa0, 18'd1);
      check("idle_chip_en", ce0, 1'b1);

      // Full write.
      xfer0("wr_full", 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 32'h0);
      check("wr_full_trace_len", tr.size(), 5);
      if (tr.size() == 5) begin
         check("wr_full_setup_data", tr[0].d, 16'hDEAD);
         check("wr_full_setup_wre", tr[0].we, 1'b1);
         check("wr_full_hacc_wre", tr[1].we, 1'b0);
         check("wr_full_hacc_oute", tr[1].oe, 1'b1);
         check("wr_full_lacc_data", tr[3].d, 16'hBEEF);
         check("wr_full_lacc_addr", tr[3].a, 18'd5);
      end
      check("wr_full_mem4", mem0[4], 16'hDEAD);
      check("wr_full_mem5", mem0[5], 16'hBEEF);
      check("wr_full_idle_bus", sd0, PROBE);

      // Lowest byte only: HI half skipped.
      xfer0("wr_be1", 1'b1, 32'h8, 32'h000000AA, 4'b0001, 32'h0);
      check("wr_be1_trace_len", tr.size(), 3);
      if (tr.size() == 3) begin
         check("wr_be1_addr", tr[0].a, 18'd5);
         check("wr_be1_hb", tr[1].hb, 1'b1);
         check("wr_be1_lb", tr[1].lb, 1'b0);
      end
      check("wr_be1_mem4", mem0[4], 16'hDEAD);
      check("wr_be1_mem5", mem0[5], 16'hBEAA);

      // No enabled bytes: straight to DONE.
      xfer0("wr_be0", 1'b1, 32'h10, 32'h12345678, 4'b0000, 32'h0);
      check("wr_be0_trace_len", tr.size(), 1);
      check("wr_be0_mem8", mem0[8], 16'h1111);
      check("wr_be0_mem9", mem0[9], 16'h1111);

      xfer0("rd8", 1'b0, 32'h8, 32'h0, 4'h0, 32'hDEADBEAA);

      // Reset during LO_ACC of a read.
      req0 = 1'b1; we0 = 1'b0; ad0 = 32'h0; be0 = 4'h0;
      e.we = 1'b0; e.rdata = 32'h3c011000; e.rdy_cyc = cyc + lat(1'b0, 4'h0, W0); e.tag = "rd_abort";
      q0.push_back(e);
      @(negedge clock);
      req0 = 1'b0;
      repeat (3) @(negedge clock);
      check("abort_in_lo_acc_oute", oe0, 1'b0);
      #1 reset = 1'b0;
      #1;
      check("abort_strobes", {ce0, wre0, oe0, hb0, lb0}, 5'h1f);
      check("abort_ready", rdy0, 1'b0);
      check("abort_rdata", rd0, 32'h0);
      check("abort_addr", sa0, 18'h0);
      check("abort_bus_released", sd0, PROBE);
      q0.delete();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      xfer0("rd_after_abort", 1'b0, 32'h0, 32'h0, 4'h0, 32'h3c011000);

      // WAIT_CYCLES=3, request held across two reads.
      n_oe1 = 0;
      c = cyc;
      req1 = 1'b1; we1 = 1'b0; ad1 = 32'h0; be1 = 4'h0;
      e.we = 1'b0; e.rdata = 32'h3c011000; e.rdy_cyc = c + lat(1'b0, 4'h0, W1); e.tag = "w3_rd0";
      q1.push_back(e);
      e.rdata = 32'h12345678; e.rdy_cyc = c + 10 + lat(1'b0, 4'h0, W1); e.tag = "w3_rd4";
      q1.push_back(e);
      @(negedge clock);
      ad1 = 32'h4;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (rdy1) begin
            seen = 1'b1;
            break;
         end
         @(negedge clock);
      end
      if (!seen) check("w3_first_timeout", rdy1, 1'b1);
      repeat (2) @(negedge clock);
      req1 = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (rdy1) begin
            seen = 1'b1;
            break;
         end
         @(negedge clock);
      end
      if (!seen) check("w3_second_timeout", rdy1, 1'b1);
      repeat (3) @(negedge clock);
      check("w3_oute_low_cycles", n_oe1, 2 * 2 * W1);
      check("w3_queue_drained", q1.size(), 0);
      check("d0_queue_drained", q0.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sram_bridge.md
Name: sram_bridge

Overview:
- Sits between the Mips core and the external 16-bit asynchronous SRAM (Ram).
- Turns one 32-bit core load, store or instruction fetch into two sequential 16-bit SRAM half-accesses.
- Drives the SRAM pins and the bidirectional data bus, assembles read data big-endian, and returns a one-cycle ready pulse to the core.

Parameters:
- WAIT_CYCLES, 1, clock cycles that each SRAM half-access holds the strobes asserted (minimum 1).
- ADDR_W, 18, SRAM word-address width.
- DATA_W, 16, SRAM data width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  access request, level; sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  32  byte address; bits [1:0] ignored.
- cpu_wdata  in  32  write data.
- cpu_be  in  4  byte enables; be[3] selects bits [31:24].
- cpu_rdata  out  32  read data; valid while cpu_ready is high, held until the next accepted request.
- cpu_ready  out  1  one-cycle completion pulse.
- addr  out  ADDR_W  SRAM word address.
- data  inout  DATA_W  SRAM data bus.
- wre  out  1  SRAM write enable, active-low.
- oute  out  1  SRAM output enable, active-low.
- hb_mask  out  1  upper-byte enable, active-low.
- lb_mask  out  1  lower-byte enable, active-low.
- chip_en  out  1  SRAM chip enable, active-low.

Behaviour:
- Reset (asynchronous, reset=0), all outputs go to their idle values immediately:
  - chip_en=wre=oute=hb_mask=lb_mask=1
  - addr=0, data=Z, cpu_ready=0, cpu_rdata=0, state=IDLE
- Reset mid-access aborts the transaction. No partial cpu_ready is produced.
- Address map:
  - HI half at addr = {cpu_addr[18:2],1'b0}; LO half at {cpu_addr[18:2],1'b1}.
  - Big-endian: HI half holds cpu bits [31:16], LO half holds bits [15:0].
- Acceptance: in IDLE, cpu_req=1 latches cpu_we, cpu_addr, cpu_wdata and cpu_be. Inputs are ignored in every other state.
- States: IDLE, HI_SETUP, HI_ACC, LO_SETUP, LO_ACC, DONE.
- SETUP state (1 cycle):
  - addr is valid and chip_en=0.
  - Masks are driven from the latched enables: hb_mask=~be[3]/~be[1], lb_mask=~be[2]/~be[0] for HI/LO.
  - wre=oute=1.
  - On a write, data is driven from the SETUP cycle onward.
- ACC state (WAIT_CYCLES cycles, down-counter reloaded on entry):
  - Read: oute=0 and both masks 0. Data is captured into the matching cpu_rdata half on the clock edge that ends the last ACC cycle.
  - Write: wre=0, oute=1.
  - addr, data and the masks are stable throughout ACC.
- After HI_ACC go to LO_SETUP; after LO_ACC go to DONE.
- DONE (1 cycle):
  - cpu_ready=1, strobes deasserted, data=Z.
  - Next state is always IDLE, so back-to-back requests have one idle cycle between them.
  - The core must drop cpu_req during DONE. If cpu_req is still 1 in IDLE, a new transaction starts.
- Write-half skip: on a write, a half whose two byte enables are both 0 is skipped entirely, with no SRAM cycle. A write with cpu_be=0000 goes IDLE -> DONE.
- Reads always run both halves, ignoring cpu_be.
- Latency from the accepting edge to cpu_ready high:
  - Full access: 2*(1+WAIT_CYCLES)+1 cycles.
  - Each skipped write half removes (1+WAIT_CYCLES) cycles.
- Bus contention:
  - data is driven only in write SETUP/ACC states.
  - oute is never 0 in the same cycle that data is driven.
  - Every change of direction passes through SETUP or DONE, which gives one turnaround cycle.
- When idle, addr holds its last value and chip_en=1.

Decomposition:
- Package sram_bridge_pkg holds:
  - the state enum and the WAIT_CYCLES counter width;
  - idle strobe constants (SRAM_OFF=1'b1);
  - half-select constants HALF_HI=1'b0, HALF_LO=1'b1.
- No sub-module: a single FSM with a wait counter and a tristate assign.
- The SRAM model stays a separate module (Ram).

Test Plan:
- Read: preload words 0x3c01/0x1000 at SRAM 0/1; cpu_req, cpu_we=0, cpu_addr=0x0 -> addr goes 0 then 1, oute=0 only in ACC, cpu_rdata=0x3c011000 with cpu_ready 5 cycles after acceptance (WAIT_CYCLES=1).
- Full write: cpu_we=1, cpu_addr=0x8, cpu_wdata=0xDEADBEEF, cpu_be=1111 -> SRAM[4]=0xDEAD, SRAM[5]=0xBEEF; data=Z in DONE and IDLE.
- Partial write: cpu_be=0001 to 0x8 with 0x000000AA -> HI half skipped, only SRAM[5] low byte=0xAA (lb_mask=0, hb_mask=1); cpu_ready 3 cycles after acceptance.
- Reset mid-read: reset=0 during LO_ACC -> all strobes 1, data=Z and cpu_ready=0 immediately; the next read after reset=1 returns correct data.
- WAIT_CYCLES=3 with cpu_req held high across two reads of 0x0 and 0x4 -> each ACC lasts 3 cycles, cpu_ready every 10 cycles (9-cycle access + 1 IDLE), oute never 0 while data is driven (assertion).
